// File: rtl/mem_access_unit.sv
// MEM-stage data memory access unit: issues one registered request per load/store,
// stalls the pipeline until DMemReady or a wait-limit timeout, and formats load/store data.
module mem_access_unit #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        MemReadEN_In,
    input  logic        MemWriteEN_In,
    input  logic [1:0]  MemSize_In,
    input  logic        MemSignExt_In,
    input  logic [31:0] ALUResult_In,
    input  logic [31:0] StoreData_In,
    output logic        DMemReq,
    output logic        DMemWE,
    output logic [31:0] DMemAddr,
    output logic [31:0] DMemWData,
    output logic [3:0]  DMemByteEN,
    input  logic [31:0] DMemRData,
    input  logic        DMemReady,
    output logic [31:0] MemResult_Out,
    output logic        Stall_Out,
    output logic        MisalignExc_Out,
    output logic        BusErr_Out
);

    localparam int unsigned CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_LIMIT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state, next_state;
    logic [CW-1:0] wait_cnt;
    logic          access_en, misaligned, valid, timeout;
    logic [31:0]   st_wdata;
    logic [3:0]    st_be;
    logic [1:0]    ld_size;
    logic [1:0]    ld_lane;
    logic          ld_sext;
    logic          ld_is_load;
    logic          bus_err_q;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_data;

    always_comb begin
        access_en  = MemReadEN_In | MemWriteEN_In;
        misaligned = ((MemSize_In == 2'b01) && ALUResult_In[0]) ||
                     (MemSize_In[1] && (ALUResult_In[1:0] != 2'b00));
        valid      = access_en && !misaligned;
        timeout    = (wait_cnt == CNT_LAST);
    end

    // FSM next-state and combinational handshake outputs
    always_comb begin
        next_state      = state;
        Stall_Out       = 1'b0;
        MisalignExc_Out = 1'b0;
        case (state)
            IDLE: begin
                if (valid) begin
                    next_state = ACCESS;
                    Stall_Out  = 1'b1;
                end else if (access_en) begin
                    MisalignExc_Out = 1'b1;
                end
            end
            ACCESS: begin
                Stall_Out = 1'b1;
                if (DMemReady || timeout) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (RESET) begin
            Stall_Out       = 1'b0;
            MisalignExc_Out = 1'b0;
        end
    end

    assign BusErr_Out = bus_err_q & ~RESET;

    always_comb begin
        case (MemSize_In)
            2'b00: begin
                st_wdata = {4{StoreData_In[7:0]}};
                case (ALUResult_In[1:0])
                    2'b00:   st_be = 4'b0001;
                    2'b01:   st_be = 4'b0010;
                    2'b10:   st_be = 4'b0100;
                    default: st_be = 4'b1000;
                endcase
            end
            2'b01: begin
                st_wdata = {2{StoreData_In[15:0]}};
                st_be    = ALUResult_In[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = StoreData_In;
                st_be    = 4'b1111;
            end
        endcase
    end

    // Load formatting uses the size/lane captured at request time, not the live inputs
    always_comb begin
        case (ld_lane)
            2'b00:   ld_byte = DMemRData[7:0];
            2'b01:   ld_byte = DMemRData[15:8];
            2'b10:   ld_byte = DMemRData[23:16];
            default: ld_byte = DMemRData[31:24];
        endcase
        ld_half = ld_lane[1] ? DMemRData[31:16] : DMemRData[15:0];
        case (ld_size)
            2'b00:   ld_data = {{24{ld_sext & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{ld_sext & ld_half[15]}}, ld_half};
            default: ld_data = DMemRData;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            DMemReq       <= 1'b0;
            DMemWE        <= 1'b0;
            DMemAddr      <= '0;
            DMemWData     <= '0;
            DMemByteEN    <= '0;
            MemResult_Out <= '0;
            wait_cnt      <= '0;
            ld_size       <= '0;
            ld_lane       <= '0;
            ld_sext       <= 1'b0;
            ld_is_load    <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            if (state == IDLE && valid) begin
                DMemReq    <= 1'b1;
                DMemWE     <= MemWriteEN_In;
                DMemAddr   <= {ALUResult_In[31:2], 2'b00};
                DMemWData  <= st_wdata;
                DMemByteEN <= st_be;
                wait_cnt   <= '0;
                ld_size    <= MemSize_In;
                ld_lane    <= ALUResult_In[1:0];
                ld_sext    <= MemSignExt_In;
                ld_is_load <= ~MemWriteEN_In;
            end else if (state == ACCESS) begin
                if (DMemReady) begin
                    DMemReq <= 1'b0;
                    if (ld_is_load) begin
                        MemResult_Out <= ld_data;
                    end
                end else if (timeout) begin
                    DMemReq       <= 1'b0;
                    MemResult_Out <= '0;
                    bus_err_q     <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected requests/results are queued at drive time
// and compared when the DUT issues its request and reaches its completion cycle.
module tb_mem_access_unit;

    localparam int unsigned WL = 4;

    logic        CLOCK;
    logic        RESET;
    logic        MemReadEN_In, MemWriteEN_In;
    logic [1:0]  MemSize_In;
    logic        MemSignExt_In;
    logic [31:0] ALUResult_In, StoreData_In;
    logic        DMemReq, DMemWE;
    logic [31:0] DMemAddr, DMemWData;
    logic [3:0]  DMemByteEN;
    logic [31:0] DMemRData;
    logic        DMemReady;
    logic [31:0] MemResult_Out;
    logic        Stall_Out, MisalignExc_Out, BusErr_Out;

    mem_access_unit #(.WAIT_LIMIT(WL)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .MemReadEN_In(MemReadEN_In), .MemWriteEN_In(MemWriteEN_In),
        .MemSize_In(MemSize_In), .MemSignExt_In(MemSignExt_In),
        .ALUResult_In(ALUResult_In), .StoreData_In(StoreData_In),
        .DMemReq(DMemReq), .DMemWE(DMemWE), .DMemAddr(DMemAddr),
        .DMemWData(DMemWData), .DMemByteEN(DMemByteEN),
        .DMemRData(DMemRData), .DMemReady(DMemReady),
        .MemResult_Out(MemResult_Out), .Stall_Out(Stall_Out),
        .MisalignExc_Out(MisalignExc_Out), .BusErr_Out(BusErr_Out)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    req_t        req_q[$];
    logic [31:0] res_q[$];
    logic [31:0] exp_result;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [1:0] size,
                                               input logic sext, input logic [31:0] a);
        logic [31:0] sh;
        if (size == 2'b00) begin
            sh = rdata >> (int'(a[1:0]) * 8);
            return (sext && sh[7]) ? {24'hFFFFFF, sh[7:0]} : {24'h0, sh[7:0]};
        end else if (size == 2'b01) begin
            sh = rdata >> (int'(a[1]) * 16);
            return (sext && sh[15]) ? {16'hFFFF, sh[15:0]} : {16'h0, sh[15:0]};
        end
        return rdata;
    endfunction

    function automatic req_t model_req(input logic wr, input logic [1:0] size,
                                       input logic [31:0] a, input logic [31:0] d);
        req_t r;
        r.addr = a & 32'hFFFF_FFFC;
        r.we   = wr;
        if (size == 2'b00) begin
            r.wdata = {d[7:0], d[7:0], d[7:0], d[7:0]};
            r.be    = 4'(1 << a[1:0]);
        end else if (size == 2'b01) begin
            r.wdata = {d[15:0], d[15:0]};
            r.be    = a[1] ? 4'b1100 : 4'b0011;
        end else begin
            r.wdata = d;
            r.be    = 4'b1111;
        end
        return r;
    endfunction

    task automatic drive_idle();
        MemReadEN_In  = 1'b0;
        MemWriteEN_In = 1'b0;
        DMemReady     = 1'b0;
    endtask

    // delay = ACCESS cycles before DMemReady; delay >= WL means the memory never answers
    task automatic do_access(input string nm, input logic rd, input logic wr,
                             input logic [1:0] size, input logic sext,
                             input logic [31:0] addr, input logic [31:0] sdata,
                             input logic [31:0] rdata, input int delay);
        req_t exp_r;
        bit   tmo;
        int   acc;
        tmo = (delay >= int'(WL));
        acc = tmo ? int'(WL) : delay + 1;
        req_q.push_back(model_req(wr, size, addr, sdata));
        if (tmo)           exp_result = '0;
        else if (rd && !wr) exp_result = model_load(rdata, size, sext, addr);
        res_q.push_back(exp_result);

        @(negedge CLOCK);
        MemReadEN_In = rd; MemWriteEN_In = wr; MemSize_In = size; MemSignExt_In = sext;
        ALUResult_In = addr; StoreData_In = sdata; DMemRData = rdata; DMemReady = 1'b0;
        #1;
        check({nm, ".stall_decode"}, Stall_Out, 1);
        check({nm, ".misalign_decode"}, MisalignExc_Out, 0);
        exp_r = req_q[0];
        for (int k = 0; k < acc; k++) begin
            @(negedge CLOCK);
            DMemReady = (k == delay);
            #1;
            if (k == 0) exp_r = req_q.pop_front();
            check({nm, ".req"}, DMemReq, 1);
            check({nm, ".stall_access"}, Stall_Out, 1);
            check({nm, ".addr"}, DMemAddr, exp_r.addr);
            check({nm, ".we"}, DMemWE, exp_r.we);
            check({nm, ".wdata"}, DMemWData, exp_r.wdata);
            check({nm, ".be"}, DMemByteEN, exp_r.be);
        end
        @(negedge CLOCK);
        drive_idle();
        #1;
        check({nm, ".stall_done"}, Stall_Out, 0);
        check({nm, ".req_done"}, DMemReq, 0);
        check({nm, ".buserr_done"}, BusErr_Out, tmo);
        check({nm, ".result"}, MemResult_Out, res_q.pop_front());
        @(negedge CLOCK);
        #1;
        check({nm, ".buserr_after"}, BusErr_Out, 0);
        check({nm, ".stall_after"}, Stall_Out, 0);
    endtask

    task automatic do_misalign(input string nm, input logic [1:0] size, input logic [31:0] addr);
        @(negedge CLOCK);
        MemReadEN_In = 1'b1; MemWriteEN_In = 1'b0; MemSize_In = size;
        ALUResult_In = addr; DMemReady = 1'b1; DMemRData = 32'hA5A5_A5A5;
        #1;
        check({nm, ".exc"}, MisalignExc_Out, 1);
        check({nm, ".stall"}, Stall_Out, 0);
        check({nm, ".req"}, DMemReq, 0);
        @(negedge CLOCK);
        MemReadEN_In = 1'b0;
        #1;
        check({nm, ".exc_off"}, MisalignExc_Out, 0);
        check({nm, ".req_after"}, DMemReq, 0);
        check({nm, ".result_kept"}, MemResult_Out, exp_result);
        DMemReady = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        drive_idle();
        MemSize_In = 2'b00; MemSignExt_In = 1'b0;
        ALUResult_In = '0; StoreData_In = '0; DMemRData = '0;
        exp_result = '0;
        repeat (2) @(negedge CLOCK);
        MemReadEN_In = 1'b1; MemSize_In = 2'b10; ALUResult_In = 32'h0000_0100;
        #1;
        check("rst.stall", Stall_Out, 0);
        check("rst.req", DMemReq, 0);
        check("rst.addr", DMemAddr, 0);
        check("rst.be", DMemByteEN, 0);
        check("rst.result", MemResult_Out, 0);
        @(negedge CLOCK);
        RESET = 1'b0;
        drive_idle();

        do_access("lw100",   1, 0, 2'b10, 0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0);
        do_access("lb103s",  1, 0, 2'b00, 1, 32'h0000_0103, 32'h0,         32'h80FF_FF12, 0);
        do_access("lb103z",  1, 0, 2'b00, 0, 32'h0000_0103, 32'h0,         32'h80FF_FF12, 1);
        do_access("sh202",   0, 1, 2'b01, 0, 32'h0000_0202, 32'h1234_ABCD, 32'h0,         0);
        do_access("sb001",   0, 1, 2'b00, 0, 32'h0000_0001, 32'h0000_005A, 32'h0,         2);
        do_access("lh006s",  1, 0, 2'b01, 1, 32'h0000_0006, 32'h0,         32'h8001_7FFF, 1);
        do_access("lh004s",  1, 0, 2'b01, 1, 32'h0000_0004, 32'h0,         32'h8001_7FFF, 3);
        do_access("both11",  1, 1, 2'b11, 0, 32'h0000_0010, 32'hCAFE_F00D, 32'h0,         0);
        do_misalign("mis_lw101", 2'b10, 32'h0000_0101);
        do_misalign("mis_lh203", 2'b01, 32'h0000_0203);
        do_access("timeout", 1, 0, 2'b10, 0, 32'h0000_0300, 32'h0,         32'h1111_1111, 99);
        do_access("lw_post", 1, 0, 2'b10, 0, 32'h0000_0400, 32'h0,         32'h7777_0001, 0);

        // reset during the second ACCESS cycle
        @(negedge CLOCK);
        MemReadEN_In = 1'b0; MemWriteEN_In = 1'b1; MemSize_In = 2'b10;
        ALUResult_In = 32'h0000_0500; StoreData_In = 32'h0BAD_0BAD; DMemReady = 1'b0;
        #1;
        check("rstacc.stall_decode", Stall_Out, 1);
        @(negedge CLOCK);
        #1;
        check("rstacc.req1", DMemReq, 1);
        @(negedge CLOCK);
        RESET = 1'b1;
        #1;
        check("rstacc.stall_in_reset", Stall_Out, 0);
        @(negedge CLOCK);
        RESET = 1'b0;
        drive_idle();
        exp_result = '0;
        #1;
        check("rstacc.req", DMemReq, 0);
        check("rstacc.we", DMemWE, 0);
        check("rstacc.addr", DMemAddr, 0);
        check("rstacc.wdata", DMemWData, 0);
        check("rstacc.be", DMemByteEN, 0);
        check("rstacc.result", MemResult_Out, exp_result);
        check("rstacc.stall", Stall_Out, 0);
        @(negedge CLOCK);
        #1;
        check("rstacc.buserr", BusErr_Out, 0);
        check("rstacc.req_after", DMemReq, 0);

        do_access("lw_after_rst", 1, 0, 2'b10, 0, 32'h0000_0600, 32'h0, 32'h0123_4567, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
